alu_wide_seq: RTL

Multi-cycle sequencer that runs NBYTES-wide add, subtract and logic operations on the 8-bit combinational ALU, one byte per cycle, least-significant byte first. The carry is chained through the ALU shift-carry path. It sits between the decode/control logic and the ALU: it accepts one wide command with a start/done handshake, drives the ALU's Type, M_op, operand and carry-in inputs, and accumulates the per-byte results into a wide result register.

---
 rtl/alu_wide_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_wide_seq.sv
// Multi-cycle wide add/sub/logic sequencer driving an external 8-bit ALU one byte per
// cycle, least-significant byte first, with the carry chained through the ALU.
module alu_wide_seq #(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  zflag,
    output logic [1:0]            alu_type,
    output logic [2:0]            alu_mop,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_sci,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sco
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpXor = 3'b100;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            zflag_q, zflag_d;
    logic            err_q, err_d;

    logic            is_arith;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;

    assign is_arith = (op_q == OpAdd) || (op_q == OpSub);
    assign a_byte   = a_q[8*idx_q +: 8];
    assign b_byte   = b_q[8*idx_q +: 8];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zflag_d  = zflag_q;
        err_d    = err_q;
        alu_mop  = 3'b000;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_sci  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = opa;
                    b_d      = opb;
                    op_d     = op;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    zflag_d  = 1'b1;
                    carry_d  = (op == OpAdd) ? cin : (op == OpSub);
                    if (op > OpXor) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                alu_a   = a_byte;
                // Subtraction is A + ~B + 1; the +1 is the carry seeded at start.
                alu_b   = (op_q == OpSub) ? ~b_byte : b_byte;
                alu_mop = is_arith ? 3'b000 : op_q;
                alu_sci = is_arith ? carry_q : 1'b0;
                result_d[8*idx_q +: 8] = alu_rslt;
                if (is_arith) begin
                    carry_d = alu_sco;
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    cout_d  = is_arith ? alu_sco : 1'b0;
                    zflag_d = (result_d == '0);
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zflag_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zflag_q  <= zflag_d;
            err_q    <= err_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StDone) && err_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign zflag    = zflag_q;
    assign alu_type = 2'b00;

endmodule
